serial_adder: RTL and testbench

- Multi-cycle, bit-serial N-bit adder; the addition counterpart to the combinational subtractor in the arithmetic library.
- Latches two operands on a start handshake and adds one bit per clock, LSB first, through a single 1-bit full-adder cell.
- Reports the sum and carry-out with a one-cycle done pulse.
- Serves area-constrained datapaths and exercises the shared-cell, sequential-arithmetic style ahead of multiplier/divider blocks.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_full_adder.sv | 20 ++
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial arithmetic blocks.
//   - FSM state encoding (IDLE / RUN / DONE)
//   - idx_width(): width of the bit-index counter for an N-bit operand.
//     One extra bit over $clog2(N) keeps N=1 at a legal, non-zero width.
package serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int idx_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder
//   Combinational 1-bit full-adder cell shared by the serial arithmetic
//   blocks. A serial subtractor reuses it with i_b inverted and carry-in 1.
// Ports:
//   i_a, i_b   operand bits
//   i_carry    carry in
//   o_sum      sum bit
//   o_carry    carry out
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_carry,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_carry;
  assign o_carry = (i_a & i_b) | (i_a & i_carry) | (i_b & i_carry);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial N-bit unsigned adder. Operands are captured on an accepted
//   start, then one bit per clock (LSB first) passes through a single
//   full-adder cell. The completed sum and carry-out are published together
//   with a one-cycle done pulse; ports never show partial results.
// Ports:
//   i_clock    system clock, rising edge
//   i_reset_n  synchronous active-low reset, aborts any addition in flight
//   i_start    start request, only honoured in IDLE
//   i_augend   first operand, captured on the accepted-start edge
//   i_addend   second operand, captured on the accepted-start edge
//   o_busy     high in RUN and DONE
//   o_done     one-cycle result-valid pulse
//   o_sum      registered sum, held until the next result
//   o_carry    registered carry out of bit N-1, held with o_sum
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for i_start, outputs hold the last result
// RUN   | one bit per edge through the full adder, N edges total
// DONE  | result valid, o_done high for this single cycle
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_start,
  input  logic [N-1:0] i_augend,
  input  logic [N-1:0] i_addend,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_sum,
  output logic         o_carry
);

  localparam int IDXW = idx_width(N);

  if (N < 1) begin : g_bad_width
    $error("serial_adder: N must be at least 1");
  end

  logic [1:0]      state;
  logic [N-1:0]    a_sr;
  logic [N-1:0]    b_sr;
  logic [N-1:0]    res_sr;
  logic [N-1:0]    res_next;
  logic            carry;
  logic [IDXW-1:0] bit_idx;
  logic            fa_sum;
  logic            fa_carry;
  logic            last_bit;

  full_adder u_fa (
    .i_a     (a_sr[0]),
    .i_b     (b_sr[0]),
    .i_carry (carry),
    .o_sum   (fa_sum),
    .o_carry (fa_carry)
  );

  // New sum bit enters at the MSB; after N shifts bit k sits at position k.
  // Written as shift-then-overwrite so N=1 needs no special case.
  always_comb begin
    res_next        = res_sr >> 1;
    res_next[N-1]   = fa_sum;
  end

  assign last_bit = (bit_idx == IDXW'(N - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry   <= 1'b0;
      bit_idx <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_sum   <= '0;
      o_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            a_sr    <= i_augend;
            b_sr    <= i_addend;
            res_sr  <= '0;
            carry   <= 1'b0;
            bit_idx <= '0;
            o_busy  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          res_sr  <= res_next;
          carry   <= fa_carry;
          bit_idx <= bit_idx + 1'b1;
          if (last_bit) begin
            // Ports update only here, so they go straight from the old
            // result to the new one.
            o_sum   <= res_next;
            o_carry <= fa_carry;
            o_done  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       st4, busy4, done4, carry4;
  logic [3:0] a4, b4, sum4;
  logic       st1, busy1, done1, carry1;
  logic [0:0] a1, b1, sum1;

  serial_adder #(.N(4)) dut4 (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(st4),
    .i_augend(a4), .i_addend(b4),
    .o_busy(busy4), .o_done(done4), .o_sum(sum4), .o_carry(carry4)
  );

  serial_adder #(.N(1)) dut1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(st1),
    .i_augend(a1), .i_addend(b1),
    .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_carry(carry1)
  );

  typedef struct {
    logic [31:0] sum;
    logic [31:0] carry;
    int          start_cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop an expected result on every done pulse; between pulses
  // the result ports must hold the last published value.
  logic [31:0] last_sum4 = 0, last_carry4 = 0;
  logic [31:0] last_sum1 = 0, last_carry1 = 0;
  logic        prev_done4 = 1'b0, prev_done1 = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_sum4 = 0; last_carry4 = 0; prev_done4 = 1'b0;
    end else begin
      if (done4) begin
        chk("done4_width", 32'(prev_done4), 0);
        chk("busy4_in_done", 32'(busy4), 1);
        chk("done4_expected", 32'(q4.size() > 0), 1);
        if (q4.size() > 0) begin
          e4 = q4.pop_front();
          chk("sum4", 32'(sum4), e4.sum);
          chk("carry4", 32'(carry4), e4.carry);
          chk("latency4", 32'(cyc + 1 - e4.start_cyc), 5);
          last_sum4 = e4.sum;
          last_carry4 = e4.carry;
        end
      end else begin
        chk("sum4_hold", 32'(sum4), last_sum4);
        chk("carry4_hold", 32'(carry4), last_carry4);
      end
      prev_done4 = done4;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last_sum1 = 0; last_carry1 = 0; prev_done1 = 1'b0;
    end else begin
      if (done1) begin
        chk("done1_width", 32'(prev_done1), 0);
        chk("busy1_in_done", 32'(busy1), 1);
        chk("done1_expected", 32'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          e1 = q1.pop_front();
          chk("sum1", 32'(sum1), e1.sum);
          chk("carry1", 32'(carry1), e1.carry);
          chk("latency1", 32'(cyc + 1 - e1.start_cyc), 2);
          last_sum1 = e1.sum;
          last_carry1 = e1.carry;
        end
      end else begin
        chk("sum1_hold", 32'(sum1), last_sum1);
        chk("carry1_hold", 32'(carry1), last_carry1);
      end
      prev_done1 = done1;
    end
  end

  task automatic wait_idle4();
    int g = 0;
    while (busy4 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("idle4_wait", 32'(busy4), 0);
  endtask

  task automatic wait_idle1();
    int g = 0;
    while (busy1 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("idle1_wait", 32'(busy1), 0);
  endtask

  // Issue one addition at the first IDLE cycle. With hold_start, i_start
  // stays high and the operands are scrambled through RUN and DONE.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit hold_start);
    int s = int'(a) + int'(b);
    int g = 0;
    wait_idle4();
    st4 = 1'b1; a4 = a; b4 = b;
    q4.push_back('{sum: 32'(s % 16), carry: 32'(s / 16), start_cyc: cyc + 1});
    @(posedge clk); #1;
    chk("busy4_after_start", 32'(busy4), 1);
    if (hold_start) begin
      while (!done4 && g < 20) begin
        a4 = 4'($urandom); b4 = 4'($urandom);
        @(posedge clk); #1;
        g++;
      end
      chk("done4_seen_hold", 32'(done4), 1);
      a4 = 4'($urandom); b4 = 4'($urandom);
      @(posedge clk); #1;
    end
    st4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
  endtask

  task automatic run1(input logic a, input logic b);
    int s = int'(a) + int'(b);
    wait_idle1();
    st1 = 1'b1; a1 = a; b1 = b;
    q1.push_back('{sum: 32'(s % 2), carry: 32'(s / 2), start_cyc: cyc + 1});
    @(posedge clk); #1;
    chk("busy1_after_start", 32'(busy1), 1);
    st1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    st4 = 1'b0; a4 = '0; b4 = '0;
    st1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy4", 32'(busy4), 0);
    chk("rst_done4", 32'(done4), 0);
    chk("rst_sum4", 32'(sum4), 0);
    chk("rst_carry4", 32'(carry4), 0);
    chk("rst_sum1", 32'(sum1), 0);
    @(posedge clk); #1;
    chk("idle_busy4", 32'(busy4), 0);
    chk("idle_busy1", 32'(busy1), 0);

    run4(4'd7, 4'd5, 1'b0);
    wait_idle4();
    repeat (10) @(posedge clk);
    #1;
    chk("hold_sum_12", 32'(sum4), 12);
    chk("hold_carry_12", 32'(carry4), 0);

    run4(4'd15, 4'd1, 1'b0);
    run4(4'd15, 4'd15, 1'b0);

    run4(4'd3, 4'd4, 1'b1);

    // Abort at the second RUN edge: no done, result cleared.
    wait_idle4();
    st4 = 1'b1; a4 = 4'd9; b4 = 4'd8;
    @(posedge clk); #1;
    st4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_sum", 32'(sum4), 0);
    chk("abort_carry", 32'(carry4), 0);
    chk("abort_busy", 32'(busy4), 0);
    chk("abort_done", 32'(done4), 0);
    rst_n = 1'b1;
    run4(4'd1, 4'd1, 1'b0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run4(4'(a), 4'(b), 1'b0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    end

    run1(1'b1, 1'b1);
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        run1(1'(a), 1'(b));
    for (int i = 0; i < 10; i++) run1(1'($urandom), 1'($urandom));

    wait_idle4();
    wait_idle1();
    @(posedge clk); #1;
    chk("q4_drained", 32'(q4.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
